data_inf_rr_arbiter: RTL and testbench
======================================

# data_inf_rr_arbiter

Round-robin arbiter that shares one downstream `data_inf_c` stream among `NUM` upstream `data_inf_c` slaver ports. It sits in front of any single-consumer datapath that receives an array of `d_inf` streams, such as the 5-way `d_inf[4:0]` bundle. The arbiter grants one requester at a time for a burst of up to `QUANTUM` beats. It registers the selected beat into a one-stage output slice.

## Interface
- `NUM`, 5, number of upstream requesters (2..16).
- `DSIZE`, 10, data width of every stream.
- `QUANTUM`, 4, maximum beats per grant (>=1).
- `clock`  in  1  single clock for all logic and interfaces.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_inf`  data_inf_c.slaver  [NUM-1:0]  upstream streams: `valid`, `data[DSIZE-1:0]` in; `ready` out.
- `m_inf`  data_inf_c.master  1  downstream stream: `valid`, `data[DSIZE-1:0]` out; `ready` in.
- `curr_sel`  out  $clog2(NUM)  index of the current grant; 0 when idle.
- `busy`  out  1  high while in GRANT.

## Operation
- States: IDLE, GRANT. Registers: `state`, `sel`, `ptr` (round-robin start index), `cnt` (beats in current grant, 0..QUANTUM-1), `m_valid`, `m_data`.
- `load_en = !m_valid || m_inf.ready`.
- IDLE:
  - Scan `s_inf[i].valid` starting at `ptr` and wrapping modulo NUM. The first valid index wins.
  - If a winner exists: next cycle `sel`=winner, `cnt`=0, state=GRANT.
  - If no winner: stay in IDLE.
  - All `s_inf.ready`=0 in IDLE.
- GRANT:
  - `s_inf[sel].ready = load_en`. All other `ready`=0.
  - Transfer: `s_inf[sel].valid && load_en`. On a transfer, `m_data<=s_inf[sel].data`, `m_valid<=1`, and `cnt++`.
  - No load into the slice: `m_valid<=0` when `m_inf.ready && !transfer`.
  - Release when the transfer with `cnt==QUANTUM-1` occurs, or when `s_inf[sel].valid==0` in any GRANT cycle. On release: state=IDLE, `ptr<=(sel+1)%NUM`, `cnt<=0`.
- Fairness: a requester that holds `valid` continuously gets at most QUANTUM beats before every other continuously-valid requester is served once.
- A drop of `valid` by the granted requester during downstream backpressure still releases the grant. No beat is lost because no handshake occurred.
- Data order within one requester is preserved. Beats from different requesters never interleave within a grant.

## Timing
- Reset (async assert, sync-to-clock release): state=IDLE, `ptr`=0, `sel`=0, `cnt`=0, `m_inf.valid`=0, `m_inf.data`=0, all `s_inf.ready`=0, `curr_sel`=0, `busy`=0.
- Reset mid-burst: a held beat in the output slice is discarded. The upstream must re-send.
- Latency: an accepted upstream beat appears on `m_inf` on the next cycle.
- Throughput: 1 beat/cycle within a grant while `m_inf.ready`=1.
- Arbitration overhead: exactly one bubble cycle (IDLE) between consecutive grants.
- `m_inf.valid`/`data` are stable while `m_inf.ready`=0. This is standard data_inf handshake: valid never drops without ready.
- `curr_sel`/`busy` are registered and reflect `sel`/state.
- Simultaneous release and a new request at `ptr` in the same cycle: the new request is evaluated in the following IDLE cycle.

## Test plan
- Single requester: only `s_inf[2]` valid, with 6 beats 1..6 and `m_inf.ready`=1. Expect output 1,2,3,4, then 1 bubble, then 5,6. `curr_sel`=2 throughout both grants.
- All 5 requesters continuously valid, each sending its own index as data. Expect grant order 0,1,2,3,4,0 with 4 beats each and 1 bubble between grants.
- Backpressure: mid-grant, hold `m_inf.ready`=0 for 3 cycles. Expect `m_inf.data` held constant, `s_inf[sel].ready`=0, and `cnt` unchanged. The burst resumes with no loss or duplication.
- Early release: `s_inf[1]` sends 2 beats and then drops `valid`, while `s_inf[3]` is valid. Expect the grant to move to 3 after one IDLE cycle, with `ptr`=2 at the time of selection.
- Wrap-around: grant on index 4 ends, requesters 0 and 3 are valid. Expect 0 to be granted next.
- Reset mid-operation: assert `rst_n`=0 while `m_inf.valid`=1. Expect `m_inf.valid` and all `ready` to drop immediately, and after release, state=IDLE with `ptr`=0.

Source files
------------

// File: rtl/data_inf_rr_arbiter.sv
// Round-robin arbiter: NUM valid/ready upstream streams share one downstream stream.
// A grant lasts up to QUANTUM beats, and the output goes through a single register slice.
module data_inf_rr_arbiter #(
  parameter int NUM     = 5,
  parameter int DSIZE   = 10,
  parameter int QUANTUM = 4
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic [NUM-1:0]                s_inf_valid,
  input  logic [NUM-1:0][DSIZE-1:0]     s_inf_data,
  output logic [NUM-1:0]                s_inf_ready,
  output logic                          m_inf_valid,
  output logic [DSIZE-1:0]              m_inf_data,
  input  logic                          m_inf_ready,
  output logic [$clog2(NUM)-1:0]        curr_sel,
  output logic                          busy
);

  // state | meaning
  // IDLE  | no owner; scan requesters starting at ptr (one bubble cycle)
  // GRANT | sel owns the slice until QUANTUM beats or its valid drops

  localparam int SW = $clog2(NUM);
  localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nx;
  logic [SW-1:0]    sel, sel_nx, ptr, ptr_nx, win_idx, sel_inc;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             m_valid, m_valid_nx;
  logic [DSIZE-1:0] m_data, m_data_nx;
  logic             win_found, load_en, sel_valid, xfer, last_beat;
  logic [SW:0]      cand;

  assign load_en   = !m_valid || m_inf_ready;
  assign sel_valid = s_inf_valid[sel];
  assign sel_inc   = (sel == SW'(NUM - 1)) ? '0 : sel + 1'b1;
  assign last_beat = (cnt == CW'(QUANTUM - 1));

  // First valid requester at or after ptr, wrapping modulo NUM.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM; i++) begin
      cand = {1'b0, ptr} + (SW+1)'(i);
      if (cand >= (SW+1)'(NUM)) cand = cand - (SW+1)'(NUM);
      if (!win_found && s_inf_valid[cand[SW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[SW-1:0];
      end
    end
  end

  always_comb begin
    state_nx    = state;
    sel_nx      = sel;
    ptr_nx      = ptr;
    cnt_nx      = cnt;
    m_valid_nx  = m_valid;
    m_data_nx   = m_data;
    s_inf_ready = '0;
    xfer        = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nx = GRANT;
          sel_nx   = win_idx;
          cnt_nx   = '0;
        end
      end
      GRANT: begin
        s_inf_ready[sel] = load_en;
        xfer             = sel_valid && load_en;
        if (xfer) cnt_nx = cnt + 1'b1;
        // A dropped valid releases even under backpressure; nothing was handshaked.
        if (!sel_valid || (xfer && last_beat)) begin
          state_nx = IDLE;
          ptr_nx   = sel_inc;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (xfer) begin
      m_valid_nx = 1'b1;
      m_data_nx  = s_inf_data[sel];
    end else if (m_inf_ready) begin
      m_valid_nx = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= '0;
      ptr     <= '0;
      cnt     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      state   <= state_nx;
      sel     <= sel_nx;
      ptr     <= ptr_nx;
      cnt     <= cnt_nx;
      m_valid <= m_valid_nx;
      m_data  <= m_data_nx;
    end
  end

  assign m_inf_valid = m_valid;
  assign m_inf_data  = m_data;
  assign busy        = (state == GRANT);
  assign curr_sel    = busy ? sel : '0;

endmodule

// File: tb/tb_data_inf_rr_arbiter.sv
// Scoreboard bench for data_inf_rr_arbiter: directed bursts with hand-computed beat order
// and inter-beat gaps (cycles since the previous output beat).
module tb_data_inf_rr_arbiter;
  localparam int NUM = 5, DSIZE = 10, QUANTUM = 4;

  logic                      clock = 1'b0;
  logic                      rst_n;
  logic [NUM-1:0]            s_inf_valid;
  logic [NUM-1:0][DSIZE-1:0] s_inf_data;
  logic [NUM-1:0]            s_inf_ready;
  logic                      m_inf_valid;
  logic [DSIZE-1:0]          m_inf_data;
  logic                      m_inf_ready;
  logic [2:0]                curr_sel;
  logic                      busy;

  data_inf_rr_arbiter #(.NUM(NUM), .DSIZE(DSIZE), .QUANTUM(QUANTUM)) dut (
    .clock(clock), .rst_n(rst_n),
    .s_inf_valid(s_inf_valid), .s_inf_data(s_inf_data), .s_inf_ready(s_inf_ready),
    .m_inf_valid(m_inf_valid), .m_inf_data(m_inf_data), .m_inf_ready(m_inf_ready),
    .curr_sel(curr_sel), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DSIZE-1:0] data;
    int               gap;
  } exp_t;

  exp_t             exp_q[$];
  logic [DSIZE-1:0] src_q[NUM][$];
  logic [NUM-1:0]   hs;
  int vectors = 0, miscompares = 0, obs_cnt = 0, last_obs = 0, cyc = 0;

  function automatic logic [DSIZE-1:0] mk(input int src, input int seq);
    return DSIZE'(src * 64 + seq);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int src, input int n, input int seq0);
    for (int k = 0; k < n; k++) src_q[src].push_back(mk(src, seq0 + k));
  endtask

  task automatic expect_beat(input int src, input int seq, input int gap);
    exp_t e;
    e.data = mk(src, seq);
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_obs(input string name, input int target, input int budget);
    int n = 0;
    while (obs_cnt < target && n < budget) begin
      @(negedge clock); #1;
      n++;
    end
    check(name, 32'(obs_cnt >= target), 32'd1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    repeat (4) @(negedge clock);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NUM; i++) src_q[i].delete();
    s_inf_valid = '0;
    s_inf_data  = '0;
    hs          = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n = 1'b0;
    clear_sources();
    m_inf_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_m_valid", 32'(m_inf_valid), 32'd0);
    check("rst_m_data", 32'(m_inf_data), 32'd0);
    check("rst_s_ready", 32'(s_inf_ready), 32'd0);
    check("rst_curr_sel", 32'(curr_sel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clock); #2;
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Upstream sources: present the queue head, advance after a handshake.
  initial forever begin
    @(posedge clock); #1;
    for (int i = 0; i < NUM; i++) begin
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      s_inf_valid[i] = (src_q[i].size() > 0);
      s_inf_data[i]  = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  end

  // Monitor: upstream handshakes and downstream beats against the scoreboard.
  initial forever begin
    @(negedge clock);
    if (rst_n) begin
      for (int i = 0; i < NUM; i++) begin
        hs[i] = s_inf_valid[i] && s_inf_ready[i];
        if (hs[i]) begin
          check("grant_curr_sel", 32'(curr_sel), 32'(i));
          check("grant_busy", 32'(busy), 32'd1);
        end
      end
      if (m_inf_valid && m_inf_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(m_inf_data), 32'hffff_ffff);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("beat_data", 32'(m_inf_data), 32'(e.data));
          if (e.gap != 0) check("beat_gap", 32'(cyc - last_obs), 32'(e.gap));
        end
        last_obs = cyc;
        obs_cnt++;
      end
    end else begin
      hs = '0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    rst_n       = 1'b0;
    m_inf_ready = 1'b1;
    clear_sources();
    do_reset();

    // Single requester, 6 beats: 4-beat grant, one bubble, 2-beat grant.
    push(2, 6, 1);
    expect_beat(2, 1, 0); expect_beat(2, 2, 1); expect_beat(2, 3, 1);
    expect_beat(2, 4, 1); expect_beat(2, 5, 2); expect_beat(2, 6, 1);
    wait_drain("single_drain", 60);

    // All five continuously valid: 0,1,2,3,4 twice, 4 beats each.
    do_reset();
    for (int i = 0; i < NUM; i++) push(i, 8, 0);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NUM; i++)
        for (int k = 0; k < QUANTUM; k++)
          expect_beat(i, r * 4 + k, (r == 0 && i == 0 && k == 0) ? 0 : ((k == 0) ? 2 : 1));
    wait_drain("all_drain", 200);

    // Backpressure for 3 cycles with the third beat held in the slice.
    do_reset();
    base = obs_cnt;
    push(0, 4, 1);
    expect_beat(0, 1, 0); expect_beat(0, 2, 1); expect_beat(0, 3, 4); expect_beat(0, 4, 1);
    wait_obs("bp_start", base + 2, 40);
    @(posedge clock); #1;
    m_inf_ready = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("bp_valid", 32'(m_inf_valid), 32'd1);
      check("bp_data", 32'(m_inf_data), 32'(mk(0, 3)));
      check("bp_s_ready", 32'(s_inf_ready), 32'd0);
    end
    @(posedge clock); #1;
    m_inf_ready = 1'b1;
    wait_drain("bp_drain", 60);

    // Early release of 1 after 2 beats; scan from ptr=2 picks 3.
    do_reset();
    push(1, 2, 1);
    push(3, 2, 1);
    expect_beat(1, 1, 0); expect_beat(1, 2, 1); expect_beat(3, 1, 3); expect_beat(3, 2, 1);
    wait_drain("early_drain", 60);

    // Wrap-around: grant on 4 ends with 0 and 3 pending; 0 goes first.
    do_reset();
    base = obs_cnt;
    push(4, 4, 1);
    expect_beat(4, 1, 0); expect_beat(4, 2, 1); expect_beat(4, 3, 1); expect_beat(4, 4, 1);
    expect_beat(0, 1, 2); expect_beat(3, 1, 3);
    wait_obs("wrap_start", base + 1, 40);
    push(0, 1, 1);
    push(3, 1, 1);
    wait_drain("wrap_drain", 60);

    // Reset while a beat sits in the slice; afterwards ptr=0 makes 1 win over 4.
    m_inf_ready = 1'b0;
    push(2, 4, 1);
    n = 0;
    while (!m_inf_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("rm_loaded", 32'(m_inf_valid), 32'd1);
    @(negedge clock); #2;
    rst_n = 1'b0;
    #1;
    check("rm_m_valid", 32'(m_inf_valid), 32'd0);
    check("rm_s_ready", 32'(s_inf_ready), 32'd0);
    check("rm_busy", 32'(busy), 32'd0);
    clear_sources();
    @(posedge clock);
    @(negedge clock);
    rst_n       = 1'b1;
    m_inf_ready = 1'b1;
    @(negedge clock);
    check("rm_idle_busy", 32'(busy), 32'd0);
    check("rm_idle_valid", 32'(m_inf_valid), 32'd0);
    @(posedge clock); #2;
    push(1, 1, 1);
    push(4, 1, 1);
    expect_beat(1, 1, 0); expect_beat(4, 1, 3);
    wait_drain("rm_drain", 60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
